// File: rtl/block_dispatch_cu.sv
// block_dispatch_cu -- main control unit of the block-matrix coprocessor.
//
// Waits for a job flag and takes the shared memory bus through a
// request/grant handshake. It then reads a configuration word with
// R = rdata[IDX_W-1:0] and C = rdata[2*IDX_W-1:IDX_W]. Every (row, col)
// block task is issued in row-major order, round-robin across P processors.
// When all results are back, the bus is re-acquired and the status word is
// cleared.
//
// Ports:
//   i_Clock, i_Reset_n         clock (rising edge), async active-low reset
//   i_Data_Ready               job available (sampled only in IDLE)
//   o_Grant_Request / i_Grant  bus request / grant
//   o_Memory_*                 address, read strobe (1-cycle latency),
//                              write strobe, write data
//   i_Memory_Rdata             read data
//   o_Row_Index/o_Column_Index per-processor index slices (slice k = proc k)
//   o_Indexes_Ready            per-processor "indexes valid"
//   i_Indexes_Received         per-processor acknowledge
//   i_Result_Ready             per-processor completion pulse
//   o_Busy                     high whenever not IDLE
//   o_Done                     one-cycle job-complete pulse
module block_dispatch_cu #(
  parameter int P           = 4,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int IDX_W       = 8,
  parameter int CFG_ADDR    = 0,
  parameter int STATUS_ADDR = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic                 i_Data_Ready,
  output logic                 o_Grant_Request,
  input  logic                 i_Grant,
  output logic [ADDR_W-1:0]    o_Memory_Address,
  output logic                 o_Memory_Read,
  output logic                 o_Memory_Write,
  output logic [DATA_W-1:0]    o_Memory_Wdata,
  input  logic [DATA_W-1:0]    i_Memory_Rdata,
  output logic [P*IDX_W-1:0]   o_Row_Index,
  output logic [P*IDX_W-1:0]   o_Column_Index,
  output logic [P-1:0]         o_Indexes_Ready,
  input  logic [P-1:0]         i_Indexes_Received,
  input  logic [P-1:0]         i_Result_Ready,
  output logic                 o_Busy,
  output logic                 o_Done
);

  localparam int PTR_W = (P > 1) ? $clog2(P) : 1;

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_REQ_CFG      = 3'd1;
  localparam logic [2:0] S_READ_CFG1    = 3'd2;
  localparam logic [2:0] S_READ_CFG2    = 3'd3;
  localparam logic [2:0] S_DISPATCH     = 3'd4;
  localparam logic [2:0] S_DRAIN        = 3'd5;
  localparam logic [2:0] S_REQ_STATUS   = 3'd6;
  localparam logic [2:0] S_WRITE_STATUS = 3'd7;

  logic [2:0]        state_reg, state_next;
  logic [IDX_W-1:0]  rows_reg, cols_reg;   // job size R, C
  logic [IDX_W-1:0]  row_reg, col_reg;     // next task to issue
  logic [PTR_W-1:0]  ptr_reg;              // round-robin start point
  logic [P-1:0]      busy_vec, ready_vec;
  logic [P*IDX_W-1:0] row_idx_vec, col_idx_vec;

  logic              req_reg, read_reg, write_reg, busy_reg, done_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic [IDX_W-1:0]  cfg_rows, cfg_cols;
  logic              capture_go, issue_en, issue_fire, last_task;
  logic [IDX_W-1:0]  cur_rows, cur_cols, cur_row, cur_col;
  logic [P-1:0]      free_mask;
  logic              pick_found;
  logic [PTR_W-1:0]  pick_idx, cand_idx;

  assign cfg_rows = i_Memory_Rdata[IDX_W-1:0];
  assign cfg_cols = i_Memory_Rdata[2*IDX_W-1:IDX_W];

  // Upper configuration bits carry nothing for this unit.
  generate
    if (DATA_W > 2*IDX_W) begin : g_rdata_upper
      logic unused_rdata_upper;
      assign unused_rdata_upper = ^i_Memory_Rdata[DATA_W-1:2*IDX_W];
    end
  endgenerate

  // The first task (0,0) is issued on the capture edge itself, straight from
  // the read data, so dispatch starts one cycle after the configuration
  // arrives instead of two.
  assign capture_go = (state_reg == S_READ_CFG2) && i_Grant &&
                      (cfg_rows != '0) && (cfg_cols != '0);
  assign issue_en   = capture_go || (state_reg == S_DISPATCH);
  assign cur_rows   = capture_go ? cfg_rows : rows_reg;
  assign cur_cols   = capture_go ? cfg_cols : cols_reg;
  assign cur_row    = capture_go ? '0 : row_reg;
  assign cur_col    = capture_go ? '0 : col_reg;
  assign last_task  = (cur_row == cur_rows - IDX_W'(1)) &&
                      (cur_col == cur_cols - IDX_W'(1));

  // A processor is free only when it is neither working nor still offered.
  assign free_mask = ~busy_vec & ~ready_vec;

  // First free processor at or after ptr, wrapping modulo P.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int i = 0; i < P; i++) begin
      cand_idx = PTR_W'((int'(ptr_reg) + i) % P);
      if (!pick_found && free_mask[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign issue_fire = issue_en && pick_found;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:         if (i_Data_Ready) state_next = S_REQ_CFG;
      S_REQ_CFG:      if (i_Grant) state_next = S_READ_CFG1;
      S_READ_CFG1:    state_next = i_Grant ? S_READ_CFG2 : S_REQ_CFG;
      S_READ_CFG2: begin
        if (!i_Grant)                                state_next = S_REQ_CFG;
        else if ((cfg_rows == '0) || (cfg_cols == '0)) state_next = S_REQ_STATUS;
        else if (issue_fire && last_task)            state_next = S_DRAIN;
        else                                         state_next = S_DISPATCH;
      end
      S_DISPATCH:     if (issue_fire && last_task) state_next = S_DRAIN;
      S_DRAIN:        if ((busy_vec == '0) && (ready_vec == '0)) state_next = S_REQ_STATUS;
      S_REQ_STATUS:   if (i_Grant) state_next = S_WRITE_STATUS;
      S_WRITE_STATUS: state_next = i_Grant ? S_IDLE : S_REQ_STATUS;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_reg <= S_IDLE;
      rows_reg  <= '0;
      cols_reg  <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      ptr_reg   <= '0;
      req_reg   <= 1'b0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (capture_go) begin
        rows_reg <= cfg_rows;
        cols_reg <= cfg_cols;
      end
      if (issue_fire) begin
        if (cur_col == cur_cols - IDX_W'(1)) begin
          row_reg <= cur_row + IDX_W'(1);
          col_reg <= '0;
        end else begin
          row_reg <= cur_row;
          col_reg <= cur_col + IDX_W'(1);
        end
        ptr_reg <= (pick_idx == PTR_W'(P-1)) ? '0 : pick_idx + PTR_W'(1);
      end
      // Bus-facing outputs are decoded from the next state so they line up
      // with the state they belong to.
      req_reg   <= (state_next == S_REQ_CFG)   || (state_next == S_READ_CFG1) ||
                   (state_next == S_READ_CFG2) || (state_next == S_REQ_STATUS) ||
                   (state_next == S_WRITE_STATUS);
      read_reg  <= (state_next == S_READ_CFG1);
      write_reg <= (state_next == S_WRITE_STATUS);
      if ((state_next == S_READ_CFG1) || (state_next == S_READ_CFG2))
        addr_reg <= ADDR_W'(CFG_ADDR);
      else if (state_next == S_WRITE_STATUS)
        addr_reg <= ADDR_W'(STATUS_ADDR);
      else
        addr_reg <= '0;
      busy_reg  <= (state_next != S_IDLE);
      done_reg  <= (state_reg == S_WRITE_STATUS) && i_Grant;
    end
  end

  // Per-processor index registers and handshake.
  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_proc
      logic             rdy_reg, bsy_reg;
      logic [IDX_W-1:0] row_q_reg, col_q_reg;
      logic             assign_here;

      assign assign_here = issue_fire && (pick_idx == PTR_W'(gi));

      always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
          rdy_reg   <= 1'b0;
          bsy_reg   <= 1'b0;
          row_q_reg <= '0;
          col_q_reg <= '0;
        end else if (assign_here) begin
          rdy_reg   <= 1'b1;
          row_q_reg <= cur_row;
          col_q_reg <= cur_col;
        end else if (rdy_reg && i_Indexes_Received[gi]) begin
          // A result pulse in this same cycle is ignored: busy was still 0.
          rdy_reg <= 1'b0;
          bsy_reg <= 1'b1;
        end else if (bsy_reg && i_Result_Ready[gi]) begin
          bsy_reg <= 1'b0;
        end
      end

      assign ready_vec[gi]                  = rdy_reg;
      assign busy_vec[gi]                   = bsy_reg;
      assign row_idx_vec[gi*IDX_W +: IDX_W] = row_q_reg;
      assign col_idx_vec[gi*IDX_W +: IDX_W] = col_q_reg;
    end
  endgenerate

  assign o_Grant_Request  = req_reg;
  assign o_Memory_Address = addr_reg;
  assign o_Memory_Read    = read_reg;
  assign o_Memory_Write   = write_reg;
  assign o_Memory_Wdata   = '0;
  assign o_Row_Index      = row_idx_vec;
  assign o_Column_Index   = col_idx_vec;
  assign o_Indexes_Ready  = ready_vec;
  assign o_Busy           = busy_reg;
  assign o_Done           = done_reg;

endmodule

// File: tb/tb_block_dispatch_cu.sv
// Testbench for block_dispatch_cu (P=4, IDX_W=8, DATA_W=32, ADDR_W=16).
module tb_block_dispatch_cu;

  logic        clk;
  logic        rst_n;
  logic        data_ready;
  logic        grant_req;
  logic        grant;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] row_idx;
  logic [31:0] col_idx;
  logic [3:0]  idx_ready;
  logic [3:0]  idx_recv;
  logic [3:0]  res_ready;
  logic        busy;
  logic        done;

  block_dispatch_cu dut (
    .i_Clock            (clk),
    .i_Reset_n          (rst_n),
    .i_Data_Ready       (data_ready),
    .o_Grant_Request    (grant_req),
    .i_Grant            (grant),
    .o_Memory_Address   (mem_addr),
    .o_Memory_Read      (mem_read),
    .o_Memory_Write     (mem_write),
    .o_Memory_Wdata     (mem_wdata),
    .i_Memory_Rdata     (mem_rdata),
    .o_Row_Index        (row_idx),
    .o_Column_Index     (col_idx),
    .o_Indexes_Ready    (idx_ready),
    .i_Indexes_Received (idx_recv),
    .i_Result_Ready     (res_ready),
    .o_Busy             (busy),
    .o_Done             (done)
  );

  typedef struct {
    int proc;
    int row;
    int col;
  } asg_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // processor model / manual drive
  logic       auto_en;
  logic [3:0] stall;
  logic [3:0] mdl_recv, mdl_res, man_recv, man_res;
  int         ack_wait [4];
  int         res_cnt  [4];
  assign idx_recv  = auto_en ? mdl_recv : man_recv;
  assign res_ready = auto_en ? mdl_res  : man_res;

  // memory model
  logic [31:0] cfg_word;

  // monitor state
  asg_t        log_q[$];
  int          log_cyc[$];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          stab_bad = 0;
  int          addr_bad = 0;
  logic [15:0] last_wr_addr;
  logic [31:0] last_wr_data;
  logic [3:0]  prev_rdy;
  logic [7:0]  held_row [4];
  logic [7:0]  held_col [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Registered memory: data for a read strobe appears in the next cycle;
  // otherwise the bus carries junk that must never be captured.
  initial begin
    logic rd_seen;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      rd_seen = mem_read;
      #1;
      mem_rdata = rd_seen ? cfg_word : $urandom;
    end
  end

  // Processor model: ack one cycle after indexes appear, result 5 cycles later.
  initial begin
    mdl_recv = '0;
    mdl_res  = '0;
    for (int k = 0; k < 4; k++) begin
      ack_wait[k] = 0;
      res_cnt[k]  = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        mdl_recv[k] = 1'b0;
        mdl_res[k]  = 1'b0;
        if (!rst_n) begin
          ack_wait[k] = 0;
          res_cnt[k]  = 0;
        end else begin
          if (res_cnt[k] > 0) begin
            res_cnt[k]--;
            if (res_cnt[k] == 0) mdl_res[k] = 1'b1;
          end
          if (idx_ready[k] && !stall[k]) begin
            if (ack_wait[k] >= 1) begin
              mdl_recv[k] = 1'b1;
              res_cnt[k]  = 5;
              ack_wait[k] = 0;
            end else begin
              ack_wait[k]++;
            end
          end else begin
            ack_wait[k] = 0;
          end
        end
      end
    end
  end

  // Monitor: log assignments, writes; watch slice stability and idle address.
  initial begin
    asg_t a;
    prev_rdy = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (idx_ready[k] && !prev_rdy[k]) begin
          a.proc = k;
          a.row  = int'(row_idx[k*8 +: 8]);
          a.col  = int'(col_idx[k*8 +: 8]);
          held_row[k] = row_idx[k*8 +: 8];
          held_col[k] = col_idx[k*8 +: 8];
          log_q.push_back(a);
          log_cyc.push_back(cyc);
          $display("cyc %0d: assign (%0d,%0d) -> p%0d", cyc, a.row, a.col, k);
        end else if (idx_ready[k] && prev_rdy[k]) begin
          if (row_idx[k*8 +: 8] != held_row[k] || col_idx[k*8 +: 8] != held_col[k])
            stab_bad++;
        end
      end
      if (mem_write) begin
        wr_cnt++;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
        $display("cyc %0d: status write addr=%0d data=%0h", cyc, mem_addr, mem_wdata);
      end
      if (mem_read) begin
        rd_cnt++;
        $display("cyc %0d: config read addr=%0d", cyc, mem_addr);
      end
      if (!mem_write && mem_addr != 16'd0) addr_bad++;
      if (done) $display("cyc %0d: done pulse", cyc);
      prev_rdy = idx_ready;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] mk_cfg(input int r, input int c);
    return {16'h0, 8'(c), 8'(r)};
  endfunction

  function automatic longint enc(input asg_t a);
    return (longint'(a.proc) << 32) | (longint'(a.row) << 16) | longint'(a.col);
  endfunction

  task automatic check_asg(input string name, input int idx, input asg_t e);
    check({name, "_present"}, longint'(log_q.size() > idx), 1);
    if (log_q.size() > idx) check(name, enc(log_q[idx]), enc(e));
  endtask

  task automatic wait_done(input string name, input int max_cyc, output int done_at);
    int got;
    got = 0;
    done_at = -1;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (done) begin
        got = 1;
        done_at = cyc;
        break;
      end
    end
    check({name, "_done_seen"}, got, 1);
  endtask

  asg_t exp1 [6];
  asg_t exp2 [2];
  asg_t exp4 [9];

  initial begin
    int base, c0, done_at, wr0, rd0;

    // expected dispatch tables
    exp1[0] = '{0, 0, 0}; exp1[1] = '{1, 0, 1}; exp1[2] = '{2, 0, 2};
    exp1[3] = '{3, 1, 0}; exp1[4] = '{0, 1, 1}; exp1[5] = '{1, 1, 2};
    exp2[0] = '{2, 0, 0}; exp2[1] = '{3, 0, 1};
    exp4[0] = '{0, 0, 0}; exp4[1] = '{1, 0, 1}; exp4[2] = '{2, 0, 2};
    exp4[3] = '{3, 1, 0}; exp4[4] = '{0, 1, 1}; exp4[5] = '{1, 1, 2};
    exp4[6] = '{3, 2, 0}; exp4[7] = '{0, 2, 1}; exp4[8] = '{1, 2, 2};

    rst_n = 1'b0; data_ready = 1'b0; grant = 1'b0;
    auto_en = 1'b1; stall = '0; man_recv = '0; man_res = '0;
    cfg_word = 32'h0;
    repeat (3) tick();

    // reset state
    check("rst_req",   grant_req, 0);
    check("rst_ready", idx_ready, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    rst_n = 1'b1;
    tick();

    // ---- Test 1: R=2, C=3, grant always high ----
    grant = 1'b1; cfg_word = mk_cfg(2, 3);
    base = log_q.size(); wr0 = wr_cnt;
    c0 = cyc;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("t1_req_e1",  grant_req, 1);
    check("t1_read_e1", mem_read, 0);
    check("t1_busy_e1", busy, 1);
    tick();
    check("t1_read_e2", mem_read, 1);
    repeat (2) tick();
    check("t1_ready_e4", idx_ready, 4'b0001);
    wait_done("t1", 200, done_at);
    check("t1_busy_after", busy, 0);
    tick();
    check("t1_done_single", done, 0);
    check("t1_first_latency", (log_cyc.size() > base) ? log_cyc[base] - c0 : -1, 4);
    check("t1_num_asg", log_q.size() - base, 6);
    for (int i = 0; i < 6; i++) check_asg($sformatf("t1_asg%0d", i), base + i, exp1[i]);
    check("t1_writes", wr_cnt - wr0, 1);
    check("t1_wr_addr", last_wr_addr, 1);
    check("t1_wr_data", last_wr_data, 0);

    // ---- Test 2: grant withheld, then dropped in read cycle 1 ----
    grant = 1'b0; cfg_word = mk_cfg(3, 3);
    base = log_q.size(); rd0 = rd_cnt;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    repeat (10) tick();
    check("t2_req_wait",  grant_req, 1);
    check("t2_read_wait", mem_read, 0);
    grant = 1'b1;
    tick();
    check("t2_read_c1", mem_read, 1);
    grant = 1'b0;
    tick();
    check("t2_read_retry", mem_read, 0);
    check("t2_req_retry",  grant_req, 1);
    cfg_word = mk_cfg(1, 2);
    tick();
    check("t2_no_asg_yet", log_q.size() - base, 0);
    grant = 1'b1;
    wait_done("t2", 200, done_at);
    check("t2_reads", rd_cnt - rd0, 2);
    check("t2_num_asg", log_q.size() - base, 2);
    for (int i = 0; i < 2; i++) check_asg($sformatf("t2_asg%0d", i), base + i, exp2[i]);

    // ---- Test 3: R=0, C=5 -> no dispatch ----
    do_reset();
    grant = 1'b1; cfg_word = mk_cfg(0, 5);
    base = log_q.size(); wr0 = wr_cnt;
    c0 = cyc;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    wait_done("t3", 30, done_at);
    check("t3_done_latency", done_at - c0, 6);
    check("t3_num_asg", log_q.size() - base, 0);
    check("t3_writes", wr_cnt - wr0, 1);

    // ---- Test 4: p2 never acks until released ----
    do_reset();
    grant = 1'b1; cfg_word = mk_cfg(3, 3); stall = 4'b0100;
    base = log_q.size(); wr0 = wr_cnt;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (log_q.size() - base >= 9) break;
      tick();
    end
    repeat (15) tick();
    check("t4_drain_busy",  busy, 1);
    check("t4_drain_nowr",  wr_cnt - wr0, 0);
    check("t4_p2_held",     idx_ready[2], 1);
    check("t4_p2_row",      row_idx[23:16], 0);
    check("t4_p2_col",      col_idx[23:16], 2);
    stall = 4'b0000;
    wait_done("t4", 60, done_at);
    check("t4_num_asg", log_q.size() - base, 9);
    for (int i = 0; i < 9; i++) check_asg($sformatf("t4_asg%0d", i), base + i, exp4[i]);

    // ---- Test 5: spurious / same-cycle result pulses ignored ----
    do_reset();
    auto_en = 1'b0;
    grant = 1'b1; cfg_word = mk_cfg(1, 1);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    repeat (3) tick();
    check("t5_ready_p0", idx_ready, 4'b0001);
    man_res = 4'b1000;
    tick();
    man_res = 4'b0000;
    check("t5_spurious_p3", idx_ready, 4'b0001);
    man_recv = 4'b0001; man_res = 4'b0001;
    tick();
    man_recv = 4'b0000; man_res = 4'b0000;
    check("t5_ack_clears", idx_ready, 4'b0000);
    repeat (6) tick();
    check("t5_still_drain_req", grant_req, 0);
    check("t5_still_busy", busy, 1);
    man_res = 4'b0001;
    tick();
    man_res = 4'b0000;
    wait_done("t5", 10, done_at);
    auto_en = 1'b1;

    // ---- Test 6: async reset mid-dispatch ----
    do_reset();
    grant = 1'b1; cfg_word = mk_cfg(2, 3); stall = 4'b1111;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    repeat (5) tick();
    check("t6_outstanding", idx_ready, 4'b0111);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_ready", idx_ready, 0);
    check("t6_async_row",   row_idx, 0);
    check("t6_async_col",   col_idx, 0);
    check("t6_async_busy",  busy, 0);
    check("t6_async_req",   grant_req, 0);
    check("t6_async_addr",  mem_addr, 0);
    stall = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("t6_idle_busy", busy, 0);
    check("t6_idle_req",  grant_req, 0);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("t6_restart_req", grant_req, 1);
    wait_done("t6", 200, done_at);

    check("slice_stable", stab_bad, 0);
    check("addr_idle_zero", addr_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
